// File: rtl/in_unit_fifo.sv
// Router input-port stage: DEPTH-entry flit FIFO with registered backpressure and XY route request for the head flit.
// Optional `IN_UNIT_STALL_CNT_EN` adds a saturating count of cycles upstream was held off by `full`.
module in_unit_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int LOC_X      = 0,
  parameter int LOC_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  full,
  input  logic                  grant,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [4:0]            route_req
`ifdef IN_UNIT_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [1:0]       LOC_X_C = 2'(LOC_X);
  localparam logic             LOC_Y_C = 1'(LOC_Y);

  // Route bit positions within route_req
  localparam int R_XP    = 0;
  localparam int R_XM    = 1;
  localparam int R_YP    = 2;
  localparam int R_YM    = 3;
  localparam int R_LOCAL = 4;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             wr_en;
  logic             rd_en;

  logic [1:0]       dest_x;
  logic             dest_y;

  // Writes are gated by the registered full only, so a pop never frees a slot in the same cycle.
  always_comb begin
    wr_en    = data_valid_in && !full_q;
    rd_en    = grant && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage is not reset; stale entries are hidden by count_q == 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign full       = full_q;
  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem[rd_ptr_q] : '0;
  assign dest_x     = head_data[1:0];
  assign dest_y     = head_data[2];

  // Dimension-ordered routing: resolve X fully before considering Y.
  always_comb begin
    route_req = '0;
    if (head_valid) begin
      if (dest_x > LOC_X_C) begin
        route_req[R_XP] = 1'b1;
      end else if (dest_x < LOC_X_C) begin
        route_req[R_XM] = 1'b1;
      end else if (dest_y > LOC_Y_C) begin
        route_req[R_YP] = 1'b1;
      end else if (dest_y < LOC_Y_C) begin
        route_req[R_YM] = 1'b1;
      end else begin
        route_req[R_LOCAL] = 1'b1;
      end
    end
  end

`ifdef IN_UNIT_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (data_valid_in && full_q && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_in_unit_fifo.sv
// Self-checking bench for in_unit_fifo: queue model compared every cycle plus directed literal checks.
module tb_in_unit_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LX    = 1;
  localparam int LY    = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic          grant = 1'b0;
  logic          full;
  logic [DW-1:0] head_data;
  logic          head_valid;
  logic [4:0]    route_req;
`ifdef IN_UNIT_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  in_unit_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .LOC_X(LX),
    .LOC_Y(LY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .data_valid_in(data_valid_in),
    .full(full),
    .grant(grant),
    .head_data(head_data),
    .head_valid(head_valid),
    .route_req(route_req)
`ifdef IN_UNIT_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: a plain queue of accepted flits plus the registered full flag.
  logic [DW-1:0] mq[$];
  bit            m_full = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit wr, rd;
    if (!rst_n) begin
      mq.delete();
      m_full = 1'b0;
    end else begin
      wr = data_valid_in && !m_full;
      rd = grant && (mq.size() != 0);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(data_in);
      m_full = (mq.size() == DEPTH);
    end
  end

  function automatic logic [4:0] route_of(logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[1:0]);
    dy = int'(f[2]);
    if (dx > LX) return 5'b00001;
    if (dx < LX) return 5'b00010;
    if (dy > LY) return 5'b00100;
    if (dy < LY) return 5'b01000;
    return 5'b10000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] eh;
    eh = (mq.size() != 0) ? mq[0] : '0;
    check("cyc_full", 32'(full), 32'(m_full));
    check("cyc_head_valid", 32'(head_valid), 32'(mq.size() != 0));
    check("cyc_head_data", 32'(head_data), 32'(eh));
    check("cyc_route", 32'(route_req), (mq.size() != 0) ? 32'(route_of(eh)) : 32'd0);
  end

  // One cycle: drive inputs just after a falling edge, return at the next falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic g);
    data_valid_in = v;
    data_in       = d;
    grant         = g;
    @(negedge clk);
    $display("txn t=%0t v=%0b d=%04h g=%0b -> full=%0b hv=%0b head=%04h route=%05b",
             $time, v, d, g, full, head_valid, head_data, route_req);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] exp_v;
  logic [DW-1:0] routes_d[4];
  logic [4:0]    routes_e[4];
  logic [DW-1:0] fl[5];

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle after reset, then grants on empty must change nothing
    check("rst_full", 32'(full), 32'd0);
    check("rst_head_valid", 32'(head_valid), 32'd0);
    check("rst_head_data", 32'(head_data), 32'd0);
    check("rst_route", 32'(route_req), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
    check("empty_grant_hv", 32'(head_valid), 32'd0);

    // Routing with LOC=(1,0)
    routes_d[0] = 16'hA003; routes_e[0] = 5'b00001;
    routes_d[1] = 16'hA104; routes_e[1] = 5'b00010;
    routes_d[2] = 16'hA205; routes_e[2] = 5'b00100;
    routes_d[3] = 16'hA301; routes_e[3] = 5'b10000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, routes_d[i], 1'b0);
      check($sformatf("route_%0d", i), 32'(route_req), 32'(routes_e[i]));
      step(1'b0, 16'h0000, 1'b1);
    end
    check("route_drained", 32'(head_valid), 32'd0);

    // Empty + write + grant: grant ignored, flit stored
    step(1'b1, 16'h5A5A, 1'b1);
    check("ewg_hv", 32'(head_valid), 32'd1);
    check("ewg_data", 32'(head_data), 32'h5A5A);
    step(1'b0, 16'h0000, 1'b1);
    check("ewg_empty", 32'(head_valid), 32'd0);

    // Fill to full, hold E, pop one, E accepted exactly once
    fl[0] = 16'h0A00; fl[1] = 16'h0B01; fl[2] = 16'h0C02; fl[3] = 16'h0D03; fl[4] = 16'h0E04;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, fl[i], 1'b0);
      check($sformatf("fill_nfull_%0d", i), 32'(full), 32'd0);
    end
    step(1'b1, fl[3], 1'b0);
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, fl[4], 1'b0);
    check("hold_full", 32'(full), 32'd1);
    check("hold_head_A", 32'(head_data), 32'(fl[0]));
    step(1'b1, fl[4], 1'b1);
    check("pop_nfull", 32'(full), 32'd0);
    check("pop_head_B", 32'(head_data), 32'(fl[1]));
    step(1'b1, fl[4], 1'b0);
    check("E_in_full", 32'(full), 32'd1);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("order_%0d", i), 32'(head_data), 32'(fl[i]));
      step(1'b0, 16'h0000, 1'b1);
    end
    check("order_empty", 32'(head_valid), 32'd0);

    // Sustained write+pop from count=2 with wrap
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h0101, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_v = 16'h0100 + 16'(i);
      check($sformatf("stream_head_%0d", i), 32'(head_data), 32'(exp_v));
      step(1'b1, 16'h0102 + 16'(i), 1'b1);
      check($sformatf("stream_nfull_%0d", i), 32'(full), 32'd0);
    end
    for (int i = 10; i < 12; i++) begin
      exp_v = 16'h0100 + 16'(i);
      check($sformatf("stream_tail_%0d", i), 32'(head_data), 32'(exp_v));
      step(1'b0, 16'h0000, 1'b1);
    end
    check("stream_empty", 32'(head_valid), 32'd0);

    // Asynchronous reset mid-stream with count=3
    step(1'b1, 16'h0203, 1'b0);
    step(1'b1, 16'h0204, 1'b0);
    step(1'b1, 16'h0205, 1'b0);
    data_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_hv", 32'(head_valid), 32'd0);
    check("arst_data", 32'(head_data), 32'd0);
    check("arst_route", 32'(route_req), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0301, 1'b0);
    step(1'b1, 16'h0302, 1'b0);
    check("post_rst_first", 32'(head_data), 32'h0301);
    step(1'b0, 16'h0000, 1'b1);
    check("post_rst_second", 32'(head_data), 32'h0302);
    step(1'b0, 16'h0000, 1'b1);

`ifdef IN_UNIT_STALL_CNT_EN
    do_reset();
    check("stall_rst", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h04FF, 1'b0);
    check("stall_5", 32'(stall_cnt), 32'd5);
    data_valid_in = 1'b1;
    repeat (70000) @(negedge clk);
    check("stall_sat", 32'(stall_cnt), 32'hFFFF);
    data_valid_in = 1'b0;
`endif

    do_reset();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/in_unit_fifo.md
# in_unit_fifo

Router input-port stage sitting directly downstream of a neighbouring router's output unit (or the local NI). It accepts one flit per cycle under a registered `full` backpressure handshake and buffers flits in a DEPTH-entry circular FIFO. For the head flit it computes a one-hot XY-routing request that feeds the switch allocator. The allocator's `grant` pops the head flit, which the crossbar then forwards.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `LOC_X`, 0: this router's X coordinate, 0..3.
- `LOC_Y`, 0: this router's Y coordinate, 0..1.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  `DATA_WIDTH`  flit from upstream; dest_x = data_in[1:0], dest_y = data_in[2].
- `data_valid_in`  in  1  upstream flit valid.
- `full`  out  1  registered backpressure to upstream.
- `grant`  in  1  allocator pops head flit this cycle.
- `head_data`  out  `DATA_WIDTH`  current head flit, 0 when empty.
- `head_valid`  out  1  FIFO not empty.
- `route_req`  out  5  one-hot {LOCAL, Y-, Y+, X-, X+} for the head flit; 0 when empty.
- `stall_cnt`  out  16  present only with `IN_UNIT_STALL_CNT_EN`.

## Operation
- Storage: DEPTH x `DATA_WIDTH` array, `wr_ptr`/`rd_ptr` of log2(DEPTH) bits that wrap naturally, `count` of log2(DEPTH)+1 bits.
- Write: occurs on an edge where `data_valid_in`=1 and `full`=0. The flit goes to mem[wr_ptr], and wr_ptr increments.
- A write is never taken while `full`=1, even if `grant` pops in the same cycle. There is no full-cycle bypass. Upstream holds its flit and valid while `full`=1, so no flit is lost or duplicated.
- Read: occurs on an edge where `grant`=1 and `count`!=0. rd_ptr increments. A `grant` while empty is ignored, with no pointer or count change.
- Count:
  - write only: +1.
  - pop only: -1.
  - both: unchanged.
- `full` is registered as (next count == DEPTH).
- Head outputs are combinational from mem[rd_ptr] and count. `head_data` is forced to 0 when empty.
- Route computation, with unsigned compares on the head flit:
  - dest_x>LOC_X gives X+ (bit0).
  - dest_x<LOC_X gives X- (bit1).
  - Otherwise, dest_y>LOC_Y gives Y+ (bit2).
  - dest_y<LOC_Y gives Y- (bit3).
  - Otherwise LOCAL (bit4).
- Exactly one bit of `route_req` is set when `head_valid`=1.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, count and `full` are cleared to 0.
  - `head_valid`, `head_data` and `route_req` are 0.
  - `stall_cnt` is 0.
  - Memory contents are not reset; they are masked by count==0.
- Flits in flight at reset are discarded.

## Timing
- Write-to-head latency: 1 cycle. A flit written at edge k appears on `head_*`/`route_req` after edge k if the FIFO was empty.
- Pop latency: 0 cycles from `grant` to consumption. The next head is visible after the popping edge.
- `full` changes 1 cycle after the count reaches or leaves DEPTH.
  - Full→not-full: a pop at edge k deasserts `full` after edge k. The upstream write can land at edge k+1.
- Throughput: 1 flit/cycle sustained with simultaneous write and pop whenever count is between 1 and DEPTH-1.
- Boundaries:
  - Empty plus write plus grant: the grant is ignored and the write is stored, so count=1.
  - count=DEPTH-1 plus write plus no pop: `full`=1 after the edge.
  - Pointer wrap from DEPTH-1 to 0 is seamless.

## Configuration
- `IN_UNIT_STALL_CNT_EN` defined:
  - Adds output `stall_cnt[15:0]`, which increments on every edge where `data_valid_in`=1 and `full`=1.
  - It saturates at 16'hFFFF and is cleared only by reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then idle → `full`=0, `head_valid`=0, `head_data`=0, `route_req`=5'b0. A `grant` pulse leaves all unchanged.
- LOC_X=1, LOC_Y=0; write flits with dest (3,0), (0,1), (1,1), (1,0), popping each → `route_req` = 00001, 00010, 00100, 10000 in order.
- DEPTH=4; write 4 flits A..D with no grant → `full`=1 after the 4th edge. Hold E valid for 3 cycles. Then pop 1 → `full`=0 the next cycle, E is accepted once, and the pop order is A,B,C,D,E with no duplicates.
- Continuous write plus grant for 10 cycles from count=2 → count stays at 2, pointers wrap, and data order is preserved.
- Assert `rst_n`=0 asynchronously mid-stream with count=3 → outputs are cleared immediately without a clock edge. The first flit after reset release is popped first.
- With `IN_UNIT_STALL_CNT_EN`: hold valid while full for 5 cycles → `stall_cnt`=5. Force 70000 stall cycles → `stall_cnt`=16'hFFFF.
